// File: rtl/ex_mem_pipe_stage_pkg.sv
// Shared pipeline-register definitions: default field widths and the packed
// EX/MEM payload type used by stage registers across the pipeline.
package ex_mem_pipe_stage_pkg;

    localparam int DEF_WB_W    = 2;
    localparam int DEF_M_W     = 3;
    localparam int DEF_JADDR_W = 8;
    localparam int DEF_STAT_W  = 8;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_RADDR_W = 5;

    typedef struct packed {
        logic [DEF_WB_W-1:0]    wb;
        logic [DEF_M_W-1:0]     m;
        logic [DEF_JADDR_W-1:0] jump_address;
        logic [DEF_STAT_W-1:0]  alu_status;
        logic [DEF_DATA_W-1:0]  alu_result;
        logic [DEF_DATA_W-1:0]  write_data;
        logic [DEF_RADDR_W-1:0] regdst_address;
    } ex_mem_pay_t;

    // Total packed payload width for a given set of field widths.
    function automatic int pay_width(input int wb, input int m, input int j,
                                     input int s, input int d, input int r);
        return wb + m + j + s + 2 * d + r;
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline holding slot: a valid bit plus a packed payload register.
// Clear wins over load; payload is zeroed only by reset.
module pipe_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with a skid slot: full throughput while MEM drains,
// and a registered in_ready so backpressure never forms a combinational path.
module ex_mem_pipe_stage
    import ex_mem_pipe_stage_pkg::*;
#(
    parameter int WB_W    = DEF_WB_W,
    parameter int M_W     = DEF_M_W,
    parameter int JADDR_W = DEF_JADDR_W,
    parameter int STAT_W  = DEF_STAT_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RADDR_W = DEF_RADDR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WB_W-1:0]    WB,
    input  logic [M_W-1:0]     M,
    input  logic [JADDR_W-1:0] jump_address,
    input  logic [STAT_W-1:0]  ALU_status,
    input  logic [DATA_W-1:0]  ALU_result,
    input  logic [DATA_W-1:0]  write_data,
    input  logic [RADDR_W-1:0] RegDst_address,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WB_W-1:0]    _WB,
    output logic [M_W-1:0]     _M,
    output logic [JADDR_W-1:0] _jump_address,
    output logic [STAT_W-1:0]  _ALU_status,
    output logic [DATA_W-1:0]  _ALU_result,
    output logic [DATA_W-1:0]  _write_data,
    output logic [RADDR_W-1:0] _RegDst_address,
    output logic [1:0]         occupancy
);

    localparam int PAY_W = pay_width(WB_W, M_W, JADDR_W, STAT_W, DATA_W, RADDR_W);

    logic [PAY_W-1:0] w_in_pay, w_main_pay, w_skid_pay, w_main_d;
    logic             w_main_vld, w_skid_vld, w_in_xfer, w_drain;
    logic             w_main_load, w_main_clr, w_skid_load, w_skid_clr, w_skid_vld_nxt;
    logic [WB_W-1:0]  w_wb;
    logic [M_W-1:0]   w_m;
    logic             r_in_ready;

    assign w_in_pay  = {WB, M, jump_address, ALU_status, ALU_result, write_data, RegDst_address};
    assign w_in_xfer = in_valid && r_in_ready;
    assign w_drain   = !w_main_vld || out_ready;

    always_comb begin
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        w_main_d    = w_in_pay;
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end else if (w_drain) begin
            if (w_skid_vld) begin
                // Oldest entry sits in skid; it must reach main before any new input.
                w_main_load = 1'b1;
                w_main_d    = w_skid_pay;
                w_skid_load = w_in_xfer;
                w_skid_clr  = !w_in_xfer;
            end else if (w_in_xfer) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clr = 1'b1;
            end
        end else if (w_in_xfer) begin
            w_skid_load = 1'b1;
        end
    end

    assign w_skid_vld_nxt = !w_skid_clr && (w_skid_load || w_skid_vld);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_in_ready <= 1'b0;
        else     r_in_ready <= !w_skid_vld_nxt;
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk(clk), .rst(rst), .i_clr(w_main_clr), .i_load(w_main_load),
        .i_data(w_main_d), .o_valid(w_main_vld), .o_data(w_main_pay)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk(clk), .rst(rst), .i_clr(w_skid_clr), .i_load(w_skid_load),
        .i_data(w_in_pay), .o_valid(w_skid_vld), .o_data(w_skid_pay)
    );

    assign {w_wb, w_m, _jump_address, _ALU_status, _ALU_result, _write_data, _RegDst_address} = w_main_pay;

    // A bubble must never trigger a write-back or memory access downstream.
    assign _WB       = w_main_vld ? w_wb : '0;
    assign _M        = w_main_vld ? w_m  : '0;
    assign out_valid = w_main_vld;
    assign in_ready  = r_in_ready;
    assign occupancy = {1'b0, w_main_vld} + {1'b0, w_skid_vld};

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage: a FIFO-level model checked every cycle,
// plus literal expectations for streaming, backpressure, flush, bubble, reset, width.
module tb_ex_mem_pipe_stage;

    localparam int WB_W = 2, M_W = 3, JADDR_W = 8, STAT_W = 8, DATA_W = 64, RADDR_W = 6;
    localparam int PW = WB_W + M_W + JADDR_W + STAT_W + 2 * DATA_W + RADDR_W;

    logic               clk = 1'b0;
    logic               rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [WB_W-1:0]    WB, _WB;
    logic [M_W-1:0]     M, _M;
    logic [JADDR_W-1:0] jump_address, _jump_address;
    logic [STAT_W-1:0]  ALU_status, _ALU_status;
    logic [DATA_W-1:0]  ALU_result, _ALU_result, write_data, _write_data;
    logic [RADDR_W-1:0] RegDst_address, _RegDst_address;
    logic [1:0]         occupancy;
    logic [PW-1:0]      pay_in, dut_pay;

    int n_vec = 0;
    int n_err = 0;

    logic [PW-1:0] q[$];
    logic          m_rdy;

    ex_mem_pipe_stage #(
        .WB_W(WB_W), .M_W(M_W), .JADDR_W(JADDR_W), .STAT_W(STAT_W),
        .DATA_W(DATA_W), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .WB(WB), .M(M), .jump_address(jump_address), .ALU_status(ALU_status),
        .ALU_result(ALU_result), .write_data(write_data), .RegDst_address(RegDst_address),
        .out_valid(out_valid), .out_ready(out_ready),
        ._WB(_WB), ._M(_M), ._jump_address(_jump_address), ._ALU_status(_ALU_status),
        ._ALU_result(_ALU_result), ._write_data(_write_data),
        ._RegDst_address(_RegDst_address), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    assign pay_in  = {WB, M, jump_address, ALU_status, ALU_result, write_data, RegDst_address};
    assign dut_pay = {_WB, _M, _jump_address, _ALU_status, _ALU_result, _write_data, _RegDst_address};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: the stage is a FIFO of depth two whose ready flag reflects
    // the fill level after the previous edge.
    initial begin
        logic in_f;
        m_rdy = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                m_rdy = 1'b0;
            end else if (flush) begin
                q.delete();
                m_rdy = 1'b1;
            end else begin
                in_f = in_valid && m_rdy;
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_f) q.push_back(pay_in);
                m_rdy = (q.size() < 2);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("model_in_ready", 64'(in_ready), 64'(m_rdy));
            chk("model_occupancy", 64'(occupancy), 64'(q.size()));
            n_vec++;
            if (q.size() > 0) begin
                if (dut_pay !== q[0]) begin
                    n_err++;
                    $display("FAIL model_payload: got %0h, expected %0h (t=%0t)", dut_pay, q[0], $time);
                end
            end else if (rst) begin
                if (dut_pay !== '0) begin
                    n_err++;
                    $display("FAIL reset_payload: got %0h, expected 0 (t=%0t)", dut_pay, $time);
                end
            end else if ({_WB, _M} !== '0) begin
                n_err++;
                $display("FAIL bubble_ctrl: got %0h, expected 0 (t=%0t)", {_WB, _M}, $time);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [63:0] r, input logic [5:0] rd);
        in_valid       = v;
        ALU_result     = r;
        RegDst_address = rd;
        WB             = r[1:0];
        M              = r[2:0];
        jump_address   = r[7:0] ^ 8'hA5;
        ALU_status     = ~r[7:0];
        write_data     = r * 3;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        put(1'b0, 64'h0, 6'h0);
        repeat (3) step();
        chk("reset_out_valid", 64'(out_valid), 64'h0);
        chk("reset_in_ready", 64'(in_ready), 64'h0);
        chk("reset_occupancy", 64'(occupancy), 64'h0);
        rst = 1'b0;
        step();
        chk("post_reset_in_ready", 64'(in_ready), 64'h1);

        // Streaming
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(1'b1, 64'(i), 6'(i));
            step();
            chk("stream_result", _ALU_result, 64'(i));
            chk("stream_occupancy", 64'(occupancy), 64'h1);
        end
        put(1'b0, 64'h0, 6'h0);
        step();
        chk("stream_drained", 64'(out_valid), 64'h0);

        // Backpressure
        out_ready = 1'b0;
        put(1'b1, 64'h11, 6'h1);
        step();
        chk("bp_A_out", _ALU_result, 64'h11);
        put(1'b1, 64'h22, 6'h2);
        step();
        chk("bp_A_held", _ALU_result, 64'h11);
        chk("bp_in_ready", 64'(in_ready), 64'h0);
        chk("bp_occupancy", 64'(occupancy), 64'h2);
        put(1'b1, 64'h33, 6'h3);
        repeat (2) step();
        chk("bp_still_A", _ALU_result, 64'h11);
        out_ready = 1'b1;
        step();
        chk("bp_B_out", _ALU_result, 64'h22);
        chk("bp_ready_again", 64'(in_ready), 64'h1);
        step();
        chk("bp_C_out", _ALU_result, 64'h33);
        put(1'b0, 64'h0, 6'h0);
        step();
        chk("bp_empty", 64'(out_valid), 64'h0);

        // Flush with a concurrent input that must be discarded
        out_ready = 1'b0;
        put(1'b1, 64'h55, 6'h5);
        step();
        put(1'b1, 64'h66, 6'h6);
        step();
        chk("fl_occupancy_pre", 64'(occupancy), 64'h2);
        flush = 1'b1; out_ready = 1'b1;
        put(1'b1, 64'h44, 6'h4);
        step();
        flush = 1'b0;
        put(1'b0, 64'h0, 6'h0);
        chk("fl_out_valid", 64'(out_valid), 64'h0);
        chk("fl_wb", 64'(_WB), 64'h0);
        chk("fl_m", 64'(_M), 64'h0);
        chk("fl_occupancy", 64'(occupancy), 64'h0);
        chk("fl_in_ready", 64'(in_ready), 64'h1);
        repeat (2) begin
            step();
            chk("fl_no_D", 64'(out_valid), 64'h0);
        end

        // Bubble with live control on the inputs
        in_valid = 1'b0; WB = 2'b11; M = 3'b111;
        repeat (3) begin
            step();
            chk("bubble_wb", 64'(_WB), 64'h0);
            chk("bubble_m", 64'(_M), 64'h0);
        end

        // Wide fields
        put(1'b1, 64'hDEADBEEF_CAFEF00D, 6'h3F);
        step();
        chk("wide_result", _ALU_result, 64'hDEADBEEF_CAFEF00D);
        chk("wide_regdst", 64'(_RegDst_address), 64'h3F);
        put(1'b0, 64'h0, 6'h0);
        step();

        // Asynchronous reset while full
        out_ready = 1'b0;
        put(1'b1, 64'h77, 6'h7);
        step();
        put(1'b1, 64'h88, 6'h8);
        step();
        put(1'b0, 64'h0, 6'h0);
        chk("rst_mid_occ_pre", 64'(occupancy), 64'h2);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'h0);
        chk("rst_mid_result", _ALU_result, 64'h0);
        chk("rst_mid_occupancy", 64'(occupancy), 64'h0);
        chk("rst_mid_in_ready", 64'(in_ready), 64'h0);
        step();
        rst = 1'b0;
        step();
        chk("rst_rel_in_ready", 64'(in_ready), 64'h1);
        chk("rst_rel_out_valid", 64'(out_valid), 64'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
